// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibits the bus, issues a start bit, shifts a byte plus odd parity on device clocks, checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] RELEASE   = 3'd2;
  localparam logic [2:0] BITS      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       clkSyncR;
  logic [1:0]       dataSyncR;
  logic             clkPrev;
  logic             clkS;
  logic             dataS;
  logic             fell;

  logic [2:0]       state;
  logic [INH_W-1:0] inhCnt;
  logic [TO_W-1:0]  toCnt;
  logic [8:0]       shiftR;
  logic [3:0]       edgeCnt;
  logic             dataOeR;
  logic             ackOk;
  logic             doneR;
  logic             errR;
  logic             toActive;
  logic             timedOut;

  // Synchronizers reset to 1 so an idle (pulled-up) bus never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkSyncR  <= 2'b11;
      dataSyncR <= 2'b11;
      clkPrev   <= 1'b1;
    end else begin
      clkSyncR  <= {clkSyncR[0], ps2_clk_i};
      dataSyncR <= {dataSyncR[0], ps2_data_i};
      clkPrev   <= clkSyncR[1];
    end
  end

  assign clkS  = clkSyncR[1];
  assign dataS = dataSyncR[1];
  assign fell  = clkPrev & ~clkS;

  assign toActive = (state == RELEASE) || (state == BITS) ||
                    (state == ACK) || (state == WAIT_IDLE);
  assign timedOut = toActive && (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      inhCnt  <= '0;
      toCnt   <= '0;
      shiftR  <= '0;
      edgeCnt <= '0;
      dataOeR <= 1'b0;
      ackOk   <= 1'b0;
      doneR   <= 1'b0;
      errR    <= 1'b0;
    end else begin
      doneR <= 1'b0;
      errR  <= 1'b0;
      if (toActive && toCnt != TO_W'(TIMEOUT_CYCLES))
        toCnt <= toCnt + TO_W'(1);

      // Timeout wins over any edge arriving in the same cycle.
      if (timedOut) begin
        state   <= IDLE;
        dataOeR <= 1'b0;
        errR    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid) begin
              shiftR <= {~^tx_data, tx_data};
              inhCnt <= '0;
              toCnt  <= '0;
              state  <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inhCnt == INH_W'(INHIBIT_CYCLES - 1)) begin
              dataOeR <= 1'b1;
              state   <= RELEASE;
            end else if (inhCnt != INH_W'(INHIBIT_CYCLES)) begin
              inhCnt <= inhCnt + INH_W'(1);
            end
          end
          RELEASE: begin
            edgeCnt <= '0;
            state   <= BITS;
          end
          BITS: begin
            // Ones shift in behind parity, so the tenth edge releases data for the stop bit.
            if (fell) begin
              dataOeR <= ~shiftR[0];
              shiftR  <= {1'b1, shiftR[8:1]};
              if (edgeCnt == 4'd9) begin
                state <= ACK;
              end else begin
                edgeCnt <= edgeCnt + 4'd1;
              end
            end
          end
          ACK: begin
            if (fell) begin
              ackOk <= ~dataS;
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clkS && dataS) begin
              doneR <= ackOk;
              errR  <= ~ackOk;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready    = (state == IDLE);
  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = dataOeR;
  assign tx_done     = doneR;
  assign tx_err      = errR;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, the number of clk cycles ps2 clock is held low before start (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, the abort limit in clk cycles from clock release to transfer end (20 ms).
REQ-003 SHALL have port clk, input, 1, the system clock.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port tx_data, input, 8, the command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid, input, 1, request to send tx_data.
REQ-007 SHALL have port tx_ready, output, 1, block idle and able to accept a byte.
REQ-008 SHALL have port ps2_clk_i, input, 1, the raw PS2_CLK line level (asynchronous).
REQ-009 SHALL have port ps2_data_i, input, 1, the raw PS2_DATA line level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe, output, 1: 1 pulls PS2_CLK low, 0 releases it.
REQ-011 SHALL have port ps2_data_oe, output, 1: 1 pulls PS2_DATA low, 0 releases it.
REQ-012 SHALL have port tx_done, output, 1, a one-cycle pulse on an acknowledged transfer.
REQ-013 SHALL have port tx_err, output, 1, a one-cycle pulse on a missing ack or a timeout.

Function
REQ-014 SHALL pass ps2_clk_i and ps2_data_i through 2-FF synchronizers; a falling edge is synchronized clock 1 -> 0 between consecutive cycles.
REQ-015 SHALL implement states IDLE, INHIBIT, RELEASE, BITS, ACK, WAIT_IDLE.
REQ-016 SHALL drive tx_ready = 1 only in IDLE.
REQ-017 SHALL accept a byte only on tx_valid && tx_ready: latch tx_data, compute odd parity = ~^tx_data, enter INHIBIT next cycle.
REQ-018 SHALL ignore tx_valid outside IDLE; a held tx_valid is accepted again on return to IDLE.
REQ-019 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then RELEASE.
REQ-020 RELEASE (1 cycle): ps2_clk_oe=0, ps2_data_oe=1 (start bit 0), start the timeout counter, go to BITS with edge count 0.
REQ-021 BITS: on falling edges 1..8 drive data bit D0..D7 (LSB first; ps2_data_oe = ~bit); edge 9 drives parity; edge 10 releases data (stop bit 1), then go to ACK.
REQ-022 Output levels SHALL change only in the cycle after a detected edge and hold until the next edge.
REQ-023 ACK: on the next falling edge, sample synchronized data; 0 = ack OK, 1 = no ack; then go to WAIT_IDLE.
REQ-024 WAIT_IDLE: wait until both synchronized lines are 1, then pulse tx_done (ack OK) or tx_err (no ack) and enter IDLE.
REQ-025 SHALL count the timeout from RELEASE through WAIT_IDLE; reaching TIMEOUT_CYCLES SHALL release both lines, pulse tx_err and enter IDLE that cycle, overriding any coincident edge.
REQ-026 SHALL ignore falling edges in IDLE and INHIBIT (device-initiated traffic belongs to the receiver; inhibit aborts it).
REQ-027 tx_done and tx_err SHALL never assert in the same cycle; at most one pulse per accepted byte.
REQ-028 Counters SHALL be wide enough for their parameter and SHALL saturate rather than wrap.

Reset
REQ-029 While rst=0, and immediately and asynchronously on assertion (including mid-transfer): state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, counters cleared, tx_ready=1.
REQ-030 SHALL resume from IDLE after rst deassertion with no pulse emitted for an interrupted byte.

Verification
REQ-031 Send 0xED (INHIBIT_CYCLES=20), with a device model clocking 11 edges and ack=0 -> clk low 20 cycles; data driven 1,0,1,1,0,1,1,1; parity 1; stop released; tx_done one pulse; tx_err=0.
REQ-032 Send 0xF4 with the device never pulling data low at edge 11 -> parity bit 0 observed; tx_err one pulse after the lines idle; tx_done=0.
REQ-033 Send a byte with no device clocks (TIMEOUT_CYCLES=500) -> lines released and tx_err pulsed exactly 500 cycles after RELEASE; tx_ready=1 next cycle.
REQ-034 Drop rst to 0 after edge 4 of a transfer -> ps2_clk_oe=ps2_data_oe=0 at once; no tx_done or tx_err; a new byte after release completes normally.
REQ-035 Hold tx_valid high with 0xAA then 0x55 during a transfer -> 0x55 is not sent until tx_done; then exactly one further transfer starts.
REQ-036 Toggle ps2_clk_i while IDLE -> outputs unchanged, tx_ready stays 1, no pulses.
